// File: rtl/sd_spi_pkg.sv
// Shared FSM encoding and 50 MHz timing defaults for the SD-card SPI front end.
package sd_spi_pkg;

    typedef enum logic [1:0] {StIdle, StGrant, StGap} sd_state_e;

    localparam int unsigned INIT_DIV_DEF = 62;  // ~397 kHz identification clock
    localparam int unsigned FAST_DIV_DEF = 1;   // 12.5 MHz data-transfer clock
    localparam int unsigned GAP_CLKS_DEF = 8;

endpackage

// File: rtl/sd_sck_gen.sv
// SPI clock generator: divides clk into sd_ck and emits registered edge strobes for the clients.
module sd_sck_gen
    import sd_spi_pkg::*;
#(
    parameter int unsigned DIV_W    = 8,
    parameter int unsigned INIT_DIV = INIT_DIV_DEF,
    parameter int unsigned FAST_DIV = FAST_DIV_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic div_sel,
    input  logic force_low,
    output logic sd_ck,
    output logic sck_rise,
    output logic sck_fall
);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [DIV_W-1:0] cur_div_q, cur_div_d;
    logic             sd_ck_q, sd_ck_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    always_comb begin
        div_cnt_d = div_cnt_q;
        cur_div_d = cur_div_q;
        sd_ck_d   = sd_ck_q;
        rise_d    = 1'b0;
        fall_d    = 1'b0;
        if (!run || force_low) begin
            div_cnt_d = '0;
            sd_ck_d   = 1'b0;
        end else begin
            // Ratio only changes at the start of a low phase, so no runt pulses reach the card.
            if (!sd_ck_q && (div_cnt_q == '0)) begin
                cur_div_d = div_sel ? DIV_W'(FAST_DIV) : DIV_W'(INIT_DIV);
            end
            if (div_cnt_q == cur_div_d) begin
                div_cnt_d = '0;
                sd_ck_d   = ~sd_ck_q;
                rise_d    = ~sd_ck_q;
                fall_d    = sd_ck_q;
            end else begin
                div_cnt_d = div_cnt_q + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q <= '0;
            cur_div_q <= DIV_W'(INIT_DIV);
            sd_ck_q   <= 1'b0;
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            cur_div_q <= cur_div_d;
            sd_ck_q   <= sd_ck_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
        end
    end

    assign sd_ck    = sd_ck_q;
    assign sck_rise = rise_q;
    assign sck_fall = fall_q;

endmodule

// File: rtl/sd_spi_mux.sv
// Shares one SD-card SPI pin set between NUM_CH client engines with round-robin ownership,
// a CSn-high gap between owners, and a slow/fast SCK chosen by init_done.
module sd_spi_mux
    import sd_spi_pkg::*;
#(
    parameter int unsigned NUM_CH   = 3,
    parameter int unsigned DIV_W    = 8,
    parameter int unsigned INIT_DIV = INIT_DIV_DEF,
    parameter int unsigned FAST_DIV = FAST_DIV_DEF,
    parameter int unsigned GAP_CLKS = GAP_CLKS_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              reinit,
    input  logic              sd_miso,
    output logic              sd_ck,
    output logic              sd_mosi,
    output logic              sd_csn,
    input  logic [NUM_CH-1:0] ch_req,
    input  logic [NUM_CH-1:0] ch_done,
    input  logic [NUM_CH-1:0] ch_mosi,
    input  logic [NUM_CH-1:0] ch_csn,
    output logic [NUM_CH-1:0] ch_grant,
    output logic              sck_rise,
    output logic              sck_fall,
    output logic              init_done,
    output logic              busy
);

    localparam int unsigned CH_W  = $clog2(NUM_CH);
    localparam int unsigned GAP_W = $clog2(GAP_CLKS + 1);

    sd_state_e         state_q, state_d;
    logic [CH_W-1:0]   grant_idx_q, grant_idx_d;
    logic [NUM_CH-1:0] grant_q, grant_d;
    logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
    logic              init_done_q, init_done_d;
    logic              sd_mosi_q, sd_mosi_d;
    logic              sd_csn_q, sd_csn_d;

    logic [NUM_CH-1:0] elig;
    logic [31:0]       scan;
    logic [CH_W-1:0]   scan_idx;
    logic [CH_W-1:0]   pick_idx;
    logic              pick_vld;
    logic              sck_force_low;

    // Card MISO goes straight to the clients; nothing in here consumes it.
    logic miso_unused;
    assign miso_unused = sd_miso;

    // A reinit pulse must already block the data channels in the cycle it arrives.
    always_comb begin
        elig     = (init_done_q && !reinit) ? ch_req : (ch_req & NUM_CH'(1));
        pick_vld = 1'b0;
        pick_idx = '0;
        scan     = '0;
        scan_idx = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            scan     = (32'(rr_ptr_q) + i) % NUM_CH;
            scan_idx = CH_W'(scan);
            if (!pick_vld && elig[scan_idx]) begin
                pick_vld = 1'b1;
                pick_idx = scan_idx;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        grant_idx_d   = grant_idx_q;
        grant_d       = grant_q;
        rr_ptr_d      = rr_ptr_q;
        gap_cnt_d     = gap_cnt_q;
        init_done_d   = init_done_q;
        sd_mosi_d     = 1'b1;
        sd_csn_d      = 1'b1;
        sck_force_low = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (pick_vld) begin
                    state_d     = StGrant;
                    grant_idx_d = pick_idx;
                    grant_d     = NUM_CH'(1) << pick_idx;
                end
            end
            StGrant: begin
                if (ch_done[grant_idx_q]) begin
                    state_d   = StGap;
                    grant_d   = '0;
                    gap_cnt_d = '0;
                    rr_ptr_d  = (grant_idx_q == CH_W'(NUM_CH - 1)) ? '0
                                                                   : grant_idx_q + CH_W'(1);
                    if (grant_idx_q == '0) begin
                        init_done_d = 1'b1;
                    end
                end else begin
                    sd_mosi_d = ch_mosi[grant_idx_q];
                    sd_csn_d  = ch_csn[grant_idx_q];
                end
            end
            StGap: begin
                if (sck_rise) begin
                    if (gap_cnt_q == GAP_W'(GAP_CLKS - 1)) begin
                        state_d       = StIdle;
                        sck_force_low = 1'b1;
                    end else begin
                        gap_cnt_d = gap_cnt_q + GAP_W'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        if (reinit) begin
            init_done_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            grant_idx_q <= '0;
            grant_q     <= '0;
            rr_ptr_q    <= CH_W'(1);
            gap_cnt_q   <= '0;
            init_done_q <= 1'b0;
            sd_mosi_q   <= 1'b1;
            sd_csn_q    <= 1'b1;
        end else begin
            state_q     <= state_d;
            grant_idx_q <= grant_idx_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            gap_cnt_q   <= gap_cnt_d;
            init_done_q <= init_done_d;
            sd_mosi_q   <= sd_mosi_d;
            sd_csn_q    <= sd_csn_d;
        end
    end

    sd_sck_gen #(
        .DIV_W    (DIV_W),
        .INIT_DIV (INIT_DIV),
        .FAST_DIV (FAST_DIV)
    ) u_sck_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (state_q != StIdle),
        .div_sel   (init_done_q),
        .force_low (sck_force_low),
        .sd_ck     (sd_ck),
        .sck_rise  (sck_rise),
        .sck_fall  (sck_fall)
    );

    assign sd_mosi   = sd_mosi_q;
    assign sd_csn    = sd_csn_q;
    assign ch_grant  = grant_q;
    assign init_done = init_done_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: doc/sd_spi_mux.md
Name: sd_spi_mux

Overview:
- Parametrised SD-card SPI front end: one card pin set (SCK/MOSI/CSn/MISO) shared by NUM_CH client engines (ch0 = init engine; e.g. ch1 = read, ch2 = write).
- Single-clock design. Generates SCK from a counter with a runtime-selectable divide ratio: slow before init completes, fast after.
- Issues clock-enable strobes to the clients, which run on clk; there are no derived clocks.
- Arbitrates ownership per transaction and inserts a CSn-high gap of clocks between owners. Replaces AND-combining of client MOSI/CSn with an explicit grant mux.

Parameters:
- NUM_CH, 3, number of client channels (>=2); channel 0 is the init channel.
- DIV_W, 8, width of the divide counter.
- INIT_DIV, 62, half-period minus 1 in clk cycles before init_done; 50 MHz clk gives ~397 kHz.
- FAST_DIV, 1, half-period minus 1 after init_done; 50 MHz clk gives 12.5 MHz.
- GAP_CLKS, 8, SCK rising edges with CSn=1 and MOSI=1 after each transaction.

Ports:
- clk, in, 1, system clock.
- rst_n, in, 1, asynchronous active-low reset.
- reinit, in, 1, one-clk pulse; clears init_done and returns to slow SCK.
- sd_miso, in, 1, card data out; fanned out unregistered to all clients.
- sd_ck, out, 1, SPI clock to card.
- sd_mosi, out, 1, SPI data to card.
- sd_csn, out, 1, card chip select, active low.
- ch_req, in, NUM_CH, per-channel transaction request (level).
- ch_done, in, NUM_CH, per-channel end-of-transaction pulse.
- ch_mosi, in, NUM_CH, per-channel MOSI.
- ch_csn, in, NUM_CH, per-channel CSn.
- ch_grant, out, NUM_CH, one-hot ownership.
- sck_rise, out, 1, one-clk strobe coincident with the sd_ck 0->1 edge.
- sck_fall, out, 1, one-clk strobe coincident with the sd_ck 1->0 edge.
- init_done, out, 1, set by ch_done[0] while ch0 is granted.
- busy, out, 1, FSM not in IDLE.

Behaviour:
- Reset values: sd_ck=0, sd_mosi=1, sd_csn=1, ch_grant=0, sck_rise=0, sck_fall=0, init_done=0, busy=0, div_cnt=0, rr_ptr=1, FSM=IDLE.
- SCK generation:
  - Runs only in GRANT or GAP; held low in IDLE.
  - div_cnt increments each clk. When div_cnt==cur_div: div_cnt<=0 and sd_ck toggles.
  - sck_rise/sck_fall are registered and assert in the same clk that sd_ck changes.
  - Period = 2*(cur_div+1) clk.
  - cur_div = init_done ? FAST_DIV : INIT_DIV. It is sampled only when sd_ck is low and div_cnt==0, so there are no runt pulses.
  - Leaving GAP forces sd_ck=0 and div_cnt=0.
- FSM:
  - IDLE:
    - Eligible mask = init_done ? ch_req : (ch_req & 1).
    - If the mask is nonzero, pick the first set bit at or after rr_ptr (wrap mod NUM_CH). Next clk: GRANT, with ch_grant one-hot and busy=1.
    - Requests from ch1..N-1 before init_done are held off; they are not dropped.
  - GRANT(k):
    - sd_mosi<=ch_mosi[k] and sd_csn<=ch_csn[k], registered, so there is 1 clk latency.
    - Non-granted ch_mosi/ch_csn are ignored.
    - ch_req[k] deasserting is ignored; the grant is held until ch_done[k].
    - On ch_done[k]: ch_grant<=0 next clk, go to GAP, rr_ptr<=(k+1) mod NUM_CH. If k==0, init_done<=1.
  - GAP:
    - sd_csn=1, sd_mosi=1. Count sck_rise up to GAP_CLKS, then go to IDLE. The edge count restarts at 0 on entry.
- Boundary rules:
  - ch_done on a non-granted channel: ignored.
  - ch_done and a new ch_req in the same clk: the new request is served only after GAP and IDLE, with at least 1 clk in IDLE.
  - Multiple requests: round-robin, no starvation.
  - reinit:
    - In IDLE/GAP: takes effect immediately.
    - In GRANT: init_done is cleared, but the current grant completes. Only ch0 is eligible afterwards.
    - SCK changes to slow at the next safe low point.
  - reinit coincident with ch_done[0]: reinit wins, so init_done=0.
  - Async reset mid-transaction: all outputs return to reset values immediately, with CSn high.

Decomposition:
- Package sd_spi_pkg holds:
  - the FSM state enum (IDLE, GRANT, GAP);
  - INIT_DIV/FAST_DIV defaults for a 50 MHz clk;
  - the GAP_CLKS default.
- One sub-module, sd_sck_gen, owns div_cnt, sd_ck, sck_rise/sck_fall and the cur_div latch. Its inputs are run, div_sel and force_low.

Test Plan:
- Reset, then ch_req=3'b001 -> ch_grant=001 two clks later. sd_ck period=126 clk. sck_rise exactly one clk wide per rising edge.
- Before init_done, ch_req=3'b110 for 1000 clk -> ch_grant stays 000, busy=0.
- ch0 grant, then ch_done[0] -> init_done=1. Exactly 8 sck_rise with sd_csn=1, sd_mosi=1. Then IDLE, with the next SCK period=4 clk.
- After init, ch_req=3'b110 held -> grants alternate 010, 100, 010. A GAP of 8 SCK edges separates each grant.
- During ch1 grant, toggle ch_mosi[2]/ch_csn[2] -> sd_mosi/sd_csn track only ch_mosi[1]/ch_csn[1], delayed 1 clk.
- Assert rst_n=0 mid-grant with sd_csn=0 -> in the same cycle sd_csn=1, sd_ck=0, ch_grant=0. After release, init_done=0.
